gray_rr_arb: RTL
================

# gray_rr_arb

Round-robin arbiter that shares one binary-to-Gray converter between NREQ requesters. It accepts one binary word at a time through a valid/ready handshake and drives the converter's enable/data inputs. It waits for the converter's valid, then returns the Gray result to the requester that issued the word. It sits between the request sources and the shared Gray conversion datapath.

## Interface
- NREQ, 4: number of requesters (2..8).
- MSB, 4: data width in bits, same meaning as the converter's MSB.
- TIMEOUT, 16: WAIT cycles before abort; used only with the timeout feature.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*MSB  packed words; requester k uses bits [k*MSB +: MSB]
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot response strobe, 1 cycle
- rsp_data  out  MSB  Gray result, qualified by rsp_valid
- conv_en  out  1  converter enable, 1-cycle pulse
- conv_data  out  MSB  binary word to converter
- conv_valid  in  1  converter result valid
- conv_gray  in  MSB  converter result
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  1-cycle abort pulse

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the winner by round-robin from pointer ptr, searching ptr, ptr+1 … modulo NREQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Capture req_data[winner] and the winner index.
  - Go to ISSUE.
- ISSUE: conv_en=1 and conv_data=captured word for exactly 1 cycle, then go to WAIT.
- WAIT: on conv_valid=1, capture conv_gray and go to RESP. conv_valid in any other state is ignored.
- RESP:
  - rsp_valid[winner]=1 and rsp_data=captured result for 1 cycle.
  - ptr <= winner+1 modulo NREQ.
  - Go to IDLE.
- Only one transaction is outstanding at a time. A requester may drop req_data after its req_ready cycle.
- A requester that holds req_valid across a RESP is re-arbitrated in the next IDLE cycle at normal priority.
- req_valid deasserted before acceptance means no transaction; the arbiter keeps no memory of it.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, conv_en=0, conv_data=0, busy=0, err_timeout=0.
- Accept at cycle N (IDLE): conv_en at N+1. With a 1-cycle converter, conv_valid arrives at N+2 and rsp_valid at N+3.
- Back-to-back: the earliest next accept is at N+4, so maximum throughput is 1 word per 4 cycles.
- Reset asserted mid-transaction, in any state:
  - All outputs clear immediately and the pending word is discarded; no rsp is issued.
  - ptr returns to 0.
  - A stale conv_valid after reset release is ignored because state is IDLE.
- Outputs rsp_data, conv_data and conv_en are registered. req_ready is combinational from req_valid and ptr.

## Configuration
- GRAY_ARB_TIMEOUT_EN defined:
  - WAIT has a cycle counter. If conv_valid is still absent after TIMEOUT WAIT cycles, go to RESP with rsp_data all ones.
  - err_timeout pulses in the same cycle as rsp_valid.
  - The counter clears on entry to WAIT.
- Not defined: WAIT waits indefinitely, err_timeout is tied 0 and no counter logic exists.

## Structure
- Package gray_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, RESP) and the state-width constant.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req vector and ptr. Outputs are one-hot grant, winner index and any_req.
- FSM, datapath registers and timeout counter live in gray_rr_arb.

## Test plan
- Single request, behavioral converter with 1-cycle latency:
  - Stimulus: req_valid[0] with 4'b0101 at cycle N.
  - Required: req_ready[0] at N; conv_en/conv_data=0101 at N+1; rsp_valid[0] with rsp_data=0111 at N+3.
- Fairness with all requesters:
  - Stimulus: all four req_valid held high after reset with data 1,2,3,4.
  - Required: grants in order 0,1,2,3; responses 0001, 0011, 0010, 0110; accepts spaced 4 cycles.
- Fairness with two requesters:
  - Stimulus: req1 and req3 held high continuously.
  - Required: grants alternate 1,3,1,3; requester 0 and requester 2 ports never see req_ready.
- Timeout, with GRAY_ARB_TIMEOUT_EN and TIMEOUT=16:
  - Stimulus: converter never asserts conv_valid on a request from requester 2.
  - Required: after 16 WAIT cycles, rsp_valid[2] with 1111 and err_timeout=1; the next request then completes normally.
  - Without the macro: busy stays high.
- Reset during WAIT:
  - Stimulus: assert rst while in WAIT; release; drive a late conv_valid.
  - Required: outputs zero immediately; no rsp_valid; next simultaneous req0/req3 grants requester 0.
- Exhaustive sweep:
  - Stimulus: words 0..15 through requester 1.
  - Required: every rsp_data equals b^(b>>1), e.g. 9→1101 and 15→1000.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types for the round-robin Gray conversion arbiter.
package gray_arb_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/gray_rr_arb_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             any_req
);

    int j;

    // Walk from the farthest offset back to ptr so the nearest active requester wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % int'(NREQ);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gray_rr_arb.sv
// Round-robin arbiter sharing one binary-to-Gray converter between NREQ requesters.
// Define GRAY_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles with an all-ones result.
module gray_rr_arb
    import gray_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MSB     = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*MSB-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [MSB-1:0]      rsp_data,
    output logic                conv_en,
    output logic [MSB-1:0]      conv_data,
    input  logic                conv_valid,
    input  logic [MSB-1:0]      conv_gray,
    output logic                busy,
    output logic                err_timeout
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MSB < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("gray_rr_arb: parameter out of range");
    end

    state_t           state, state_nx;
    logic [PTR_W-1:0] ptr, ptr_nx;
    logic [PTR_W-1:0] win, win_nx;
    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] pick_idx;
    logic             any_req;
    logic [NREQ-1:0]  rsp_valid_nx;
    logic [MSB-1:0]   rsp_data_nx;
    logic [MSB-1:0]   conv_data_nx;
    logic             conv_en_nx;
    logic             busy_nx;
    logic             tmo_hit;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .idx     (pick_idx),
        .any_req (any_req)
    );

`ifdef GRAY_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign tmo_hit = (state == WAIT) && !conv_valid && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // WAIT cycle counter; held at zero outside WAIT so every entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            tmo_cnt     <= (state == WAIT) ? tmo_cnt + CNT_W'(1) : '0;
            err_timeout <= tmo_hit;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            conv_en   <= 1'b0;
            conv_data <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            win       <= win_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            conv_en   <= conv_en_nx;
            conv_data <= conv_data_nx;
            busy      <= busy_nx;
        end
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        win_nx       = win;
        rsp_data_nx  = rsp_data;
        conv_data_nx = conv_data;
        req_ready    = '0;
        case (state)
            IDLE: begin
                if (any_req && !rst) begin
                    req_ready    = grant;
                    win_nx       = pick_idx;
                    conv_data_nx = req_data[int'(pick_idx) * int'(MSB) +: MSB];
                    state_nx     = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (conv_valid) begin
                    rsp_data_nx = conv_gray;
                    state_nx    = RESP;
                end else if (tmo_hit) begin
                    rsp_data_nx = '1;
                    state_nx    = RESP;
                end
            end
            RESP: begin
                ptr_nx   = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        conv_en_nx   = (state_nx == ISSUE);
        rsp_valid_nx = (state_nx == RESP) ? (NREQ'(1) << win) : '0;
        busy_nx      = (state_nx != IDLE);
    end

endmodule
